// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, writeback-select/funct3 encodings and WB state type for the MEM/WB stage.
package mem_wb_stage_pkg;

    localparam int WORD_LEN      = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam int ADDR_SIZE     = 32;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;

    typedef enum logic [1:0] {
        WB_RUN        = 2'd0,
        WB_LOAD_WAIT  = 2'd1,
        WB_LOAD_WRITE = 2'd2
    } wbState_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load alignment: picks the byte/half addressed by offset and sign/zero extends it.
module mem_wb_stage_load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [WORD_LEN-1:0] word,
    input  logic [2:0]          funct3,
    input  logic [1:0]          offset,
    output logic [WORD_LEN-1:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[7:0];
        case (offset)
            2'd0:    byteSel = word[7:0];
            2'd1:    byteSel = word[15:8];
            2'd2:    byteSel = word[23:16];
            default: byteSel = word[31:24];
        endcase
        halfSel = offset[1] ? word[31:16] : word[15:0];
    end

    // Reserved funct3 codes fall through to a full-word load.
    always_comb begin
        result = word;
        case (funct3)
            FUNCT3_LB:  result = {{(WORD_LEN-8){byteSel[7]}}, byteSel};
            FUNCT3_LBU: result = {{(WORD_LEN-8){1'b0}}, byteSel};
            FUNCT3_LH:  result = {{(WORD_LEN-16){halfSel[15]}}, halfSel};
            FUNCT3_LHU: result = {{(WORD_LEN-16){1'b0}}, halfSel};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback controller feeding the RegFile write port.
//   state         | meaning
//   WB_RUN        | non-load in WB, or empty
//   WB_LOAD_WAIT  | load captured, awaiting dmem response (MEM stalled)
//   WB_LOAD_WRITE | aligned load data latched, written this cycle
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    input  logic [ADDR_SIZE-1:0]     inPc,
    input  logic                     inRegWrite,
    input  logic [REG_IDX_WIDTH-1:0] inRd,
    input  logic [1:0]               inWbSel,
    input  logic                     inMemRead,
    input  logic [2:0]               inFunct3,
    input  logic [WORD_LEN-1:0]      inAluResult,
    input  logic [WORD_LEN-1:0]      dmemRdata,
    input  logic                     dmemRvalid,
    output logic                     stallOut,
    output logic                     writeEnable,
    output logic [REG_IDX_WIDTH-1:0] writeAddr,
    output logic [WORD_LEN-1:0]      writeData,
    output logic [ADDR_SIZE-1:0]     pc_WB,
    output logic [CNT_WIDTH-1:0]     instRetired
);

    localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

    wbState_t                 state, nextState;
    logic                     wbValid;
    logic [ADDR_SIZE-1:0]     wbPc;
    logic                     wbRegWrite;
    logic [REG_IDX_WIDTH-1:0] wbRd;
    logic [1:0]               wbWbSel;
    logic [2:0]               wbFunct3;
    logic [WORD_LEN-1:0]      wbAluResult;
    logic [WORD_LEN-1:0]      loadData;
    logic [WORD_LEN-1:0]      loadAligned;
    logic                     retiring;

    mem_wb_stage_load_extend uLoadExtend (
        .word   (dmemRdata),
        .funct3 (wbFunct3),
        .offset (wbAluResult[1:0]),
        .result (loadAligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WB_RUN;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            WB_RUN, WB_LOAD_WRITE:
                nextState = (inValid && inMemRead) ? WB_LOAD_WAIT : WB_RUN;
            WB_LOAD_WAIT:
                if (dmemRvalid) nextState = WB_LOAD_WRITE;
            default:
                nextState = WB_RUN;
        endcase
    end

    assign stallOut = (state == WB_LOAD_WAIT);
    assign retiring = wbValid && (state != WB_LOAD_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid     <= 1'b0;
            wbPc        <= '0;
            wbRegWrite  <= 1'b0;
            wbRd        <= '0;
            wbWbSel     <= WB_SEL_ALU;
            wbFunct3    <= '0;
            wbAluResult <= '0;
        end else if (!stallOut) begin
            wbValid     <= inValid;
            wbPc        <= inPc;
            wbRegWrite  <= inRegWrite;
            wbRd        <= inRd;
            wbWbSel     <= inWbSel;
            wbFunct3    <= inFunct3;
            wbAluResult <= inAluResult;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      loadData <= '0;
        else if (state == WB_LOAD_WAIT && dmemRvalid) loadData <= loadAligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           instRetired <= '0;
        else if (retiring) instRetired <= instRetired + CNT_WIDTH'(1);
    end

    always_comb begin
        writeData = wbAluResult;
        case (wbWbSel)
            WB_SEL_MEM: writeData = loadData;
            WB_SEL_PC4: writeData = WORD_LEN'(wbPc) + PC_STEP;
            default:    writeData = wbAluResult;
        endcase
    end

    assign writeEnable = retiring && wbRegWrite;
    assign writeAddr   = wbRd;
    assign pc_WB       = wbPc;

endmodule
